// File: rtl/sha256_arbiter.sv
// Round-robin arbiter that shares one SHA256 core among N_REQ requesters, one job in flight.
// Optional core watchdog: define SHA256_ARB_TIMEOUT_EN to turn a silent core into an error response.
module sha256_arbiter #(
   parameter int N_REQ   = 4,
   parameter int IDW     = $clog2(N_REQ),
   parameter int TIMEOUT = 80
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [N_REQ*440-1:0] req_msg,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 resp_valid,
   output logic [IDW-1:0]       resp_id,
   output logic [255:0]         resp_hash,
   output logic                 resp_err,
   input  logic                 resp_ready,
   output logic                 core_valid_in,
   output logic [439:0]         core_message,
   input  logic                 core_valid_out,
   input  logic [255:0]         core_hash,
   output logic                 busy,
   output logic [1:0]           dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
   // valid never waits on ready, and the response outputs hold until resp_ready.
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

   localparam logic [IDW:0] N_L = (IDW+1)'(N_REQ);

   state_t           state;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   id_q;
   logic [439:0]     msg_q;
   logic [255:0]     hash_q;
   logic             rv_q;
   logic             cvi_q;
   logic             busy_q;
   logic [439:0]     msg_arr [N_REQ];
   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0] rot;
   logic [IDW-1:0]   off;
   logic [IDW:0]     sum;
   logic [IDW-1:0]   grant_id;
   logic [N_REQ-1:0] grant;
   logic             found;

   for (genvar g = 0; g < N_REQ; g++) begin : g_msg
      assign msg_arr[g] = req_msg[g*440 +: 440];
   end

   // Rotate the request vector so bit 0 is the requester at ptr, then take the lowest set bit.
   always_comb begin
      dbl   = {req_valid, req_valid};
      rot   = N_REQ'(dbl >> ptr);
      found = 1'b0;
      off   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            off   = IDW'(k);
         end
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= N_L) sum = sum - N_L;
      grant_id = IDW'(sum);
      grant    = found ? (N_REQ'(1) << grant_id) : '0;
   end

   assign req_ready     = (state == S_IDLE && !rst) ? grant : '0;
   assign resp_valid    = rv_q;
   assign resp_id       = id_q;
   assign resp_hash     = hash_q;
   assign core_valid_in = cvi_q;
   assign core_message  = msg_q;
   assign busy          = busy_q;
   assign dbg_state     = state;

`ifdef SHA256_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wait_cnt;
   logic          err_q;
   assign resp_err = err_q;
`else
   assign resp_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         ptr    <= '0;
         id_q   <= '0;
         msg_q  <= '0;
         hash_q <= '0;
         rv_q   <= 1'b0;
         cvi_q  <= 1'b0;
         busy_q <= 1'b0;
`ifdef SHA256_ARB_TIMEOUT_EN
         wait_cnt <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  msg_q  <= msg_arr[grant_id];
                  id_q   <= grant_id;
                  ptr    <= (grant_id == IDW'(N_REQ-1)) ? '0 : grant_id + 1'b1;
                  state  <= S_ISSUE;
                  cvi_q  <= 1'b1;
                  busy_q <= 1'b1;
               end
            end
            S_ISSUE: begin
               cvi_q <= 1'b0;
               state <= S_WAIT;
`ifdef SHA256_ARB_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            S_WAIT: begin
               // A strobe in the final watchdog cycle still beats the timeout.
               if (core_valid_out) begin
                  hash_q <= core_hash;
                  state  <= S_DELIVER;
                  rv_q   <= 1'b1;
`ifdef SHA256_ARB_TIMEOUT_EN
                  err_q  <= 1'b0;
               end else if (wait_cnt == CW'(TIMEOUT-1)) begin
                  hash_q <= '0;
                  err_q  <= 1'b1;
                  state  <= S_DELIVER;
                  rv_q   <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
`endif
               end
            end
            S_DELIVER: begin
               if (resp_ready) begin
                  state  <= S_IDLE;
                  rv_q   <= 1'b0;
                  busy_q <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/sha256_arbiter.md
# sha256_arbiter

Round-robin arbiter and sequencer that shares a single SHA256 core among `N_REQ` requesters, such as script-opcode units issuing OP_SHA256 work. It sits between the requesters and the core, and owns the core's `valid_in`/`message` inputs. It issues one job at a time, captures the core's one-cycle `valid_out` result, and returns the result to the granted requester through a valid/ready response channel. An optional watchdog converts a core that never answers into an error response.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `IDW`, default `$clog2(N_REQ)`: width of the requester index.
- `TIMEOUT`, default 80: maximum cycles spent in WAIT before an error response. Used only with `SHA256_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  N_REQ: per-requester job request.
- `req_msg`  in  N_REQ*440: requester i's 440-bit message is `req_msg[i*440 +: 440]`.
- `req_ready`  out  N_REQ: one-hot grant. The handshake completes on `req_valid[i] & req_ready[i]`.
- `resp_valid`  out  1: a response is held on the response outputs.
- `resp_id`  out  IDW: index of the requester that owns the response.
- `resp_hash`  out  256: digest.
- `resp_err`  out  1: the job timed out; `resp_hash` is 0.
- `resp_ready`  in  1: response consumer accepts.
- `core_valid_in`  out  1: one-cycle start pulse to the core.
- `core_message`  out  440: message presented to the core.
- `core_valid_out`  in  1: one-cycle result strobe from the core.
- `core_hash`  in  256: core digest, valid only while `core_valid_out` is high.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- State machine: IDLE → ISSUE → WAIT → DELIVER → IDLE.
- IDLE
  - `req_ready` is the one-hot winner among `req_valid`. The search starts at the rotating pointer `ptr` and wraps from N_REQ-1 to 0.
  - If no request is valid, `req_ready` is 0.
  - On a handshake with requester i:
    - latch the message into `msg_q` and i into `id_q`;
    - set `ptr` to (i+1) mod N_REQ;
    - go to ISSUE.
- ISSUE (exactly 1 cycle)
  - `core_valid_in` = 1 and `core_message` = `msg_q`.
  - Go to WAIT and clear the wait counter.
- WAIT
  - On `core_valid_out`: latch `core_hash` into `hash_q`, clear `err_q`, go to DELIVER.
- DELIVER
  - `resp_valid` = 1, `resp_id` = `id_q`, `resp_hash` = `hash_q`, `resp_err` = `err_q`.
  - All response outputs are held stable until `resp_ready`.
  - On `resp_valid & resp_ready`: go to IDLE.
- `req_ready` is 0 in every state except IDLE. At most one job is in flight.
- `core_message` equals `msg_q` in every state. `core_valid_in` is 0 outside ISSUE.
- `core_valid_out` arriving in IDLE, ISSUE or DELIVER is ignored: no state change and no data capture.
- `ptr` advances only on a grant, so a lone persistent requester is re-granted every job.
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - state = IDLE, `ptr` = 0;
  - `req_ready` = 0 while `rst` is asserted;
  - `resp_valid` = 0, `resp_id` = 0, `resp_hash` = 0, `resp_err` = 0;
  - `core_valid_in` = 0, `core_message` = 0, `busy` = 0.
- Request accepted at edge E. ISSUE is active in cycle E+1, so `core_valid_in` is high in the cycle after the handshake.
- The core strobes `core_valid_out` about 66 cycles after `core_valid_in`. `resp_valid` rises the cycle after the strobe.
- Back-to-back jobs: at least one IDLE cycle follows each response handshake. The minimum job period is 3 + core latency + response wait.
- `rst` asserted in any state returns to reset values immediately, with no response issued.
  - The core must be reset together with the arbiter. The top level ties both resets to one source, inverted for the core's `rst_n`.

## Configuration
- `SHA256_ARB_TIMEOUT_EN` defined:
  - A wait counter increments each cycle in WAIT.
  - When it reaches TIMEOUT without `core_valid_out`, go to DELIVER with `err_q` = 1 and `hash_q` = 0.
  - A late `core_valid_out` after the timeout is ignored.
  - A strobe arriving in the same cycle the counter reaches TIMEOUT wins: the response is normal, with `resp_err` = 0.
- Not defined: no counter exists, WAIT lasts indefinitely, and `resp_err` is constant 0.

## Test plan
- Single request, stub core answering 66 cycles after start with hash 256'h1111…1111:
  - requester 2 is granted in the same cycle it raises `req_valid`;
  - `core_valid_in` pulses 1 cycle later with `req_msg[2]`;
  - `resp_valid` follows the strobe by 1 cycle with `resp_id` = 2 and `resp_hash` = 256'h1111…1111.
- All 4 requesters held valid from reset: grant order is 0,1,2,3,0,1. Responses arrive in that order, one job in flight at a time.
- Requesters 1 and 3 valid after a grant to 1: the next grant goes to 3, then 1.
- `resp_ready` held low for 20 cycles in DELIVER: response outputs remain stable, `req_ready` = 0, and any extra `core_valid_out` is ignored. Release → IDLE on the next cycle.
- With `SHA256_ARB_TIMEOUT_EN` and TIMEOUT = 80, the stub core never answers: `resp_valid` = 1 with `resp_err` = 1 and `resp_hash` = 0, 81 cycles after ISSUE. A strobe at cycle 100 is ignored.
- `rst` pulsed mid-WAIT: all outputs return to reset values asynchronously. A new request afterwards is granted starting from `ptr` = 0.
